mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the NPC's instruction-fetch and load/store initiators.
- Implements the responder end of an AXI4-Lite-style valid/ready interface: AR/R read channels, AW/W/B write channels.
- Backed by a word-addressed storage array.
- Supports fixed or pseudo-random response latency, so initiator handshake logic can be exercised under stall conditions.
- Handles one transaction at a time; there is no outstanding-request queue.

Parameters:
- BASE, 32'h8000_0000, byte address of word 0.
- DEPTH, 4096, number of 32-bit words in the storage array.
- LATENCY, 1, minimum number of cycles from request handshake to response valid (must be ≥1).
- RANDOM, 0, when set to 1, adds 0..3 extra cycles taken from LFSR bits [1:0].

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets).
- araddr  in  32  read address.
- arvalid  in  1  read request valid.
- arready  out  1  read request accepted.
- rdata  out  32  read data word.
- rresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- rvalid  out  1  read response valid.
- rready  in  1  initiator accepts read response.
- awaddr  in  32  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address accepted.
- wdata  in  32  write data.
- wstrb  in  4  byte-lane enables; bit i covers wdata[8i+7:8i].
- wvalid  in  1  write data valid.
- wready  out  1  write data accepted.
- bresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- bvalid  out  1  write response valid.
- bready  in  1  initiator accepts write response.

Behaviour:
- States:
  - IDLE.
  - RD_WAIT and RD_RESP.
  - WR_WAIT and WR_RESP.
- Reset behaviour:
  - Clocked with rst==0: state goes to IDLE; rvalid, bvalid, rresp, bresp and rdata go to 0; the latency counter clears; the LFSR is set to 8'h01.
  - While rst==0, arready, awready and wready are forced to 0.
  - Storage contents are not cleared.
- Ready signals:
  - arready = (state==IDLE).
  - awready = wready = (state==IDLE) && awvalid && wvalid && !arvalid.
- Request acceptance in IDLE:
  - A read is accepted on arvalid.
  - A write is accepted only when awvalid and wvalid are both high in the same cycle.
  - If a read and a write request coincide, the read wins. The write stays pending and is accepted in a later IDLE cycle.
- Address decode:
  - In range when BASE ≤ addr < BASE+4*DEPTH.
  - Word index = (addr-BASE)>>2.
  - addr[1:0] is ignored; byte/halfword alignment and sign extension are done by the initiator.
- Read path:
  - At AR handshake: latch the address, load the counter with LATENCY plus the extra cycles (RANDOM only), and go to RD_WAIT.
  - The counter decrements every cycle. When it reaches 1, the next edge drives:
    - rdata = mem[index], or 0 if out of range;
    - rresp = OKAY, or SLVERR if out of range;
    - rvalid = 1;
    - state = RD_RESP.
  - Result: a handshake at cycle T gives rvalid high at T+latency.
  - RD_RESP: rdata and rresp are held stable while rvalid && !rready. On rvalid && rready, rvalid drops at the next edge and the state returns to IDLE.
  - Back-to-back requests: the next request can be accepted one cycle after the response handshake.
- Write path:
  - At the AW/W handshake: if in range, write the lanes enabled in wstrb; if out of range, write nothing.
  - Then load the counter and go to WR_WAIT.
  - After the latency: bvalid = 1, bresp = OKAY or SLVERR, state = WR_RESP.
  - bvalid && bready returns the state to IDLE.
  - wstrb == 4'b0000 is legal: no bytes change and the response is OKAY.
  - A read accepted after a write's B handshake returns the new data.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Advances every non-reset cycle.
  - Its value is sampled at the request handshake.
- Initiator rules: the responder does not check that valid is held until ready. A request dropped before its handshake is not served.
- Reset in the middle of an operation: any pending response is discarded and no response is ever issued for it. A write already committed at its handshake remains in storage.

Test Plan:
- Reset and idle: hold rst=0 for 3 cycles, then release → rvalid = bvalid = 0 and arready = 0 during reset; arready = 1 in the first cycle after release.
- Write then read, LATENCY=1:
  - Write awaddr=0x8000_0010, wdata=0xDEADBEEF, wstrb=4'hF → bvalid one cycle after the handshake, bresp=00.
  - Then read araddr=0x8000_0012 → rdata=0xDEADBEEF.
- Byte strobe: preload 0x11223344, then write wdata=0xAABBCCDD with wstrb=4'b0101 → a read returns 0x11BB33DD.
- Out of range: read 0x8000_4000 with DEPTH=4096 → rresp=10, rdata=0. A write to the same address → bresp=10 and no storage change.
- Backpressure:
  - LATENCY=3: rvalid rises exactly 3 cycles after the AR handshake.
  - Hold rready=0 for 5 cycles → rdata and rresp stay stable and arready stays 0.
  - Raise rready → the state returns to IDLE on the next cycle.
- Contention and reset: assert arvalid and a write in the same cycle → the read is served first and the write is accepted after the R handshake. Pulse rst=0 during RD_WAIT → no rvalid appears and the state is IDLE after release.

Source files
------------

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - AR/R/AW/W/B valid/ready bundle between an initiator and the memory responder
interface mem_responder_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-transaction word-addressed memory responder with fixed or LFSR-jittered latency
module mem_responder #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          DEPTH   = 4096,
  parameter int          LATENCY = 1,
  parameter bit          RANDOM  = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);
  localparam int          IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW   = $clog2(LATENCY + 4) + 1;
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_RESP,
    S_WR_WAIT,
    S_WR_RESP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_lfsr;
  logic [IW-1:0] r_idx;
  logic          r_ok;
  logic [31:0]   r_rdata;
  logic [1:0]    r_rresp;
  logic          r_rvalid;
  logic [1:0]    r_bresp;
  logic          r_bvalid;
  logic [31:0]   r_mem [DEPTH];

  logic          w_idle;
  logic          w_ar_hs;
  logic          w_wr_hs;
  logic [31:0]   w_addr;
  logic [31:0]   w_off;
  logic          w_in_range;
  logic [IW-1:0] w_idx;
  logic [CW-1:0] w_lat;
  logic          w_fb;

  // Readies are gated by rst so nothing is accepted while reset is held.
  assign w_idle  = (r_state == S_IDLE) && rst;
  assign w_ar_hs = w_idle && bus.arvalid;
  assign w_wr_hs = w_idle && bus.awvalid && bus.wvalid && !bus.arvalid;

  // A read always wins in IDLE, so the decoded address follows arvalid.
  assign w_addr     = bus.arvalid ? bus.araddr : bus.awaddr;
  assign w_off      = w_addr - BASE;
  assign w_in_range = (w_addr >= BASE) && ({1'b0, w_off} < SPAN);
  assign w_idx      = w_off[IW+1:2];

  assign w_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_lat = CW'(LATENCY) + (RANDOM ? CW'(r_lfsr[1:0]) : CW'(0));

  assign bus.arready = w_idle;
  assign bus.awready = w_wr_hs;
  assign bus.wready  = w_wr_hs;
  assign bus.rdata   = r_rdata;
  assign bus.rresp   = r_rresp;
  assign bus.rvalid  = r_rvalid;
  assign bus.bresp   = r_bresp;
  assign bus.bvalid  = r_bvalid;

  // Writes commit at the handshake, so a later reset cannot undo them.
  always_ff @(posedge clk) begin
    if (w_wr_hs && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) r_mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_lfsr   <= 8'h01;
      r_rdata  <= '0;
      r_rresp  <= OKAY;
      r_rvalid <= 1'b0;
      r_bresp  <= OKAY;
      r_bvalid <= 1'b0;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
      case (r_state)
        S_IDLE: begin
          if (w_ar_hs) begin
            r_idx   <= w_idx;
            r_ok    <= w_in_range;
            r_cnt   <= w_lat;
            r_state <= S_RD_WAIT;
          end else if (w_wr_hs) begin
            r_ok    <= w_in_range;
            r_cnt   <= w_lat;
            r_state <= S_WR_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (r_cnt <= CW'(1)) begin
            r_cnt    <= '0;
            r_rdata  <= r_ok ? r_mem[r_idx] : 32'h0;
            r_rresp  <= r_ok ? OKAY : SLVERR;
            r_rvalid <= 1'b1;
            r_state  <= S_RD_RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RD_RESP: begin
          if (bus.rready) begin
            r_rvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_WR_WAIT: begin
          if (r_cnt <= CW'(1)) begin
            r_cnt    <= '0;
            r_bresp  <= r_ok ? OKAY : SLVERR;
            r_bvalid <= 1'b1;
            r_state  <= S_WR_RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_WR_RESP: begin
          if (bus.bready) begin
            r_bvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized and directed checks of mem_responder against a word-array model
module tb_mem_responder;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  mem_responder_if bus1 ();
  mem_responder_if bus3 ();
  mem_responder_if busr ();

  mem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(1), .RANDOM(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(3), .RANDOM(1'b0)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));
  mem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(1), .RANDOM(1'b1)) u_dutr (.clk(clk), .rst(rst), .bus(busr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && ({1'b0, a} < {1'b0, BASE} + 33'(DEPTH) * 33'd4);
  endfunction

  // Both drivers start and end 1 time unit after a rising edge.
  task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int lat, output logic [1:0] resp);
    int n;
    bus1.awaddr = a; bus1.wdata = d; bus1.wstrb = s; bus1.awvalid = 1'b1; bus1.wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus1.awready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus1.awvalid = 1'b0; bus1.wvalid = 1'b0;
    lat = 0;
    while (!bus1.bvalid && lat < 20) begin @(posedge clk); #1; lat++; end
    resp = bus1.bresp;
    bus1.bready = 1'b1; @(posedge clk); #1; bus1.bready = 1'b0;
    if (n >= 20) lat = -1;
  endtask

  task automatic rd1(input logic [31:0] a, input int stall, output logic [31:0] d_first, output logic [31:0] d, output logic [1:0] resp, output int lat);
    int n;
    bus1.araddr = a; bus1.arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus1.arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus1.arvalid = 1'b0;
    lat = 0;
    while (!bus1.rvalid && lat < 20) begin @(posedge clk); #1; lat++; end
    d_first = bus1.rdata;
    repeat (stall) begin @(posedge clk); #1; end
    d = bus1.rdata; resp = bus1.rresp;
    bus1.rready = 1'b1; @(posedge clk); #1; bus1.rready = 1'b0;
    if (n >= 20) lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus1.awaddr = BASE; bus1.wdata = 32'h0; bus1.wstrb = 4'hF; bus1.awvalid = 1'b1; bus1.wvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_total++; if (bus1.arready !== 1'b0) $display("FAIL reset_arready: got %b required 0", bus1.arready); else n_pass++;
      n_total++; if (bus1.awready !== 1'b0) $display("FAIL reset_awready: got %b required 0", bus1.awready); else n_pass++;
      n_total++; if (bus1.rvalid !== 1'b0 || bus1.bvalid !== 1'b0) $display("FAIL reset_valids: got r=%b b=%b required 0", bus1.rvalid, bus1.bvalid); else n_pass++;
      n_total++; if (bus3.arready !== 1'b0 || bus3.rvalid !== 1'b0) $display("FAIL reset_dut3: got ar=%b r=%b required 0", bus3.arready, bus3.rvalid); else n_pass++;
    end
    bus1.awvalid = 1'b0; bus1.wvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_total++; if (bus1.arready !== 1'b1) $display("FAIL release_arready: got %b required 1", bus1.arready); else n_pass++;
    n_total++; if (bus3.arready !== 1'b1 || busr.arready !== 1'b1) $display("FAIL release_arready_others: got %b %b required 1", bus3.arready, busr.arready); else n_pass++;
    n_total++; if (bus1.rresp !== 2'b00 || bus1.rdata !== 32'h0) $display("FAIL release_rdata: got %h/%b required 0/00", bus1.rdata, bus1.rresp); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    int lat; logic [1:0] resp; logic [31:0] d0, d;
    wr1(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, lat, resp);
    n_total++; if (lat !== 1) $display("FAIL wr_latency: got %0d required 1", lat); else n_pass++;
    n_total++; if (resp !== 2'b00) $display("FAIL wr_bresp: got %b required 00", resp); else n_pass++;
    rd1(32'h8000_0012, 0, d0, d, resp, lat);
    n_total++; if (d !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h required deadbeef", d); else n_pass++;
    n_total++; if (resp !== 2'b00) $display("FAIL rd_rresp: got %b required 00", resp); else n_pass++;
    n_total++; if (lat !== 1) $display("FAIL rd_latency: got %0d required 1", lat); else n_pass++;
  endtask

  task automatic test_byte_strobe;
    int lat; logic [1:0] resp; logic [31:0] d0, d;
    wr1(32'h8000_0020, 32'h1122_3344, 4'hF, lat, resp);
    wr1(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, lat, resp);
    n_total++; if (resp !== 2'b00) $display("FAIL strb_bresp: got %b required 00", resp); else n_pass++;
    rd1(32'h8000_0020, 0, d0, d, resp, lat);
    n_total++; if (d !== 32'h11BB_33DD) $display("FAIL strb_data: got %h required 11bb33dd", d); else n_pass++;
    wr1(32'h8000_0021, 32'hFFFF_FFFF, 4'b0000, lat, resp);
    n_total++; if (resp !== 2'b00) $display("FAIL strb0_bresp: got %b required 00", resp); else n_pass++;
    rd1(32'h8000_0020, 0, d0, d, resp, lat);
    n_total++; if (d !== 32'h11BB_33DD) $display("FAIL strb0_data: got %h required 11bb33dd", d); else n_pass++;
  endtask

  task automatic test_out_of_range;
    int lat; logic [1:0] resp; logic [31:0] d0, d;
    wr1(BASE, 32'h0BAD_F00D, 4'hF, lat, resp);
    rd1(32'h8000_4000, 0, d0, d, resp, lat);
    n_total++; if (resp !== 2'b10 || d !== 32'h0) $display("FAIL oor_read: got %h/%b required 00000000/10", d, resp); else n_pass++;
    wr1(32'h8000_4000, 32'h1234_5678, 4'hF, lat, resp);
    n_total++; if (resp !== 2'b10) $display("FAIL oor_bresp: got %b required 10", resp); else n_pass++;
    rd1(BASE, 0, d0, d, resp, lat);
    n_total++; if (d !== 32'h0BAD_F00D) $display("FAIL oor_no_alias: got %h required 0badf00d", d); else n_pass++;
    rd1(32'h7FFF_FFFC, 0, d0, d, resp, lat);
    n_total++; if (resp !== 2'b10) $display("FAIL below_base: got %b required 10", resp); else n_pass++;
    wr1(32'h8000_3FFC, 32'h5A5A_A5A5, 4'hF, lat, resp);
    rd1(32'h8000_3FFF, 0, d0, d, resp, lat);
    n_total++; if (resp !== 2'b00 || d !== 32'h5A5A_A5A5) $display("FAIL last_word: got %h/%b required 5a5aa5a5/00", d, resp); else n_pass++;
  endtask

  task automatic test_random;
    logic [31:0] model [int unsigned];
    int unsigned idxq[$];
    int unsigned idx;
    int lat; logic [1:0] resp; logic [31:0] a, d, d0, w; logic [3:0] s;
    for (int k = 0; k < 8; k++) begin
      idx = $urandom_range(0, DEPTH - 1);
      d = $urandom;
      wr1(BASE + idx * 4, d, 4'hF, lat, resp);
      model[idx] = d;
      idxq.push_back(idx);
      n_total++; if (resp !== 2'b00) $display("FAIL rnd_init_bresp: got %b required 00", resp); else n_pass++;
    end
    for (int k = 0; k < 40; k++) begin
      idx = idxq[$urandom_range(0, idxq.size() - 1)];
      a = BASE + idx * 4 + $urandom_range(0, 3);
      if (!in_range(a)) $display("bench address out of range: %h", a);
      if ($urandom_range(0, 1) == 1) begin
        s = 4'($urandom_range(0, 15));
        d = $urandom;
        wr1(a, d, s, lat, resp);
        w = model[idx];
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        model[idx] = w;
        n_total++; if (resp !== 2'b00 || lat !== 1) $display("FAIL rnd_write: got resp=%b lat=%0d required 00/1", resp, lat); else n_pass++;
      end else begin
        rd1(a, $urandom_range(0, 3), d0, d, resp, lat);
        n_total++; if (d !== model[idx] || d0 !== model[idx]) $display("FAIL rnd_read: got %h/%h required %h addr %h", d0, d, model[idx], a); else n_pass++;
        n_total++; if (resp !== 2'b00 || lat !== 1) $display("FAIL rnd_read_resp: got resp=%b lat=%0d required 00/1", resp, lat); else n_pass++;
      end
    end
  endtask

  task automatic test_contention;
    int lat; logic [1:0] resp; logic [31:0] d0, d;
    wr1(32'h8000_0040, 32'h0101_0101, 4'hF, lat, resp);
    bus1.araddr = 32'h8000_0040; bus1.arvalid = 1'b1;
    bus1.awaddr = 32'h8000_0040; bus1.wdata = 32'h0202_0202; bus1.wstrb = 4'hF; bus1.awvalid = 1'b1; bus1.wvalid = 1'b1;
    @(negedge clk);
    n_total++; if (bus1.arready !== 1'b1 || bus1.awready !== 1'b0) $display("FAIL cont_priority: got ar=%b aw=%b required 1/0", bus1.arready, bus1.awready); else n_pass++;
    @(posedge clk); #1;
    bus1.arvalid = 1'b0;
    @(negedge clk);
    n_total++; if (bus1.awready !== 1'b0) $display("FAIL cont_aw_blocked: got %b required 0", bus1.awready); else n_pass++;
    lat = 0;
    while (!bus1.rvalid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_total++; if (bus1.rdata !== 32'h0101_0101) $display("FAIL cont_read_first: got %h required 01010101", bus1.rdata); else n_pass++;
    bus1.rready = 1'b1; @(posedge clk); #1; bus1.rready = 1'b0;
    @(negedge clk);
    n_total++; if (bus1.awready !== 1'b1 || bus1.wready !== 1'b1) $display("FAIL cont_write_later: got aw=%b w=%b required 1/1", bus1.awready, bus1.wready); else n_pass++;
    @(posedge clk); #1;
    bus1.awvalid = 1'b0; bus1.wvalid = 1'b0;
    lat = 0;
    while (!bus1.bvalid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_total++; if (lat !== 1 || bus1.bresp !== 2'b00) $display("FAIL cont_bresp: got lat=%0d resp=%b required 1/00", lat, bus1.bresp); else n_pass++;
    bus1.bready = 1'b1; @(posedge clk); #1; bus1.bready = 1'b0;
    rd1(32'h8000_0040, 0, d0, d, resp, lat);
    n_total++; if (d !== 32'h0202_0202) $display("FAIL cont_new_data: got %h required 02020202", d); else n_pass++;
  endtask

  task automatic test_reset_midop;
    int lat; logic [1:0] resp; logic [31:0] d0, d;
    bus1.araddr = 32'h8000_0040; bus1.arvalid = 1'b1;
    @(posedge clk); #1;
    bus1.arvalid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_total++; if (bus1.rvalid !== 1'b0 || bus1.arready !== 1'b1) $display("FAIL midrd_reset: got rvalid=%b arready=%b required 0/1", bus1.rvalid, bus1.arready); else n_pass++;
    end
    bus1.awaddr = 32'h8000_0044; bus1.wdata = 32'h7777_0000; bus1.wstrb = 4'hF; bus1.awvalid = 1'b1; bus1.wvalid = 1'b1;
    @(posedge clk); #1;
    bus1.awvalid = 1'b0; bus1.wvalid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_total++; if (bus1.bvalid !== 1'b0) $display("FAIL midwr_reset: got bvalid=%b required 0", bus1.bvalid); else n_pass++;
    end
    rd1(32'h8000_0044, 0, d0, d, resp, lat);
    n_total++; if (d !== 32'h7777_0000) $display("FAIL midwr_committed: got %h required 77770000", d); else n_pass++;
    rd1(32'h8000_0040, 0, d0, d, resp, lat);
    n_total++; if (d !== 32'h0202_0202) $display("FAIL storage_kept: got %h required 02020202", d); else n_pass++;
  endtask

  task automatic test_backpressure;
    bus3.awaddr = BASE + 32'h14; bus3.wdata = 32'hCAFE_F00D; bus3.wstrb = 4'hF; bus3.awvalid = 1'b1; bus3.wvalid = 1'b1;
    @(negedge clk);
    n_total++; if (bus3.awready !== 1'b1) $display("FAIL bp_awready: got %b required 1", bus3.awready); else n_pass++;
    @(posedge clk); #1;
    bus3.awvalid = 1'b0; bus3.wvalid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      n_total++; if (bus3.bvalid !== 1'(k == 3)) $display("FAIL bp_b_latency: cycle %0d got %b required %b", k, bus3.bvalid, k == 3); else n_pass++;
    end
    bus3.bready = 1'b1; @(posedge clk); #1; bus3.bready = 1'b0;
    bus3.araddr = BASE + 32'h14; bus3.arvalid = 1'b1;
    @(posedge clk); #1;
    bus3.arvalid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      n_total++; if (bus3.rvalid !== 1'(k == 3)) $display("FAIL bp_r_latency: cycle %0d got %b required %b", k, bus3.rvalid, k == 3); else n_pass++;
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_total++; if (bus3.rvalid !== 1'b1 || bus3.rdata !== 32'hCAFE_F00D || bus3.rresp !== 2'b00) $display("FAIL bp_hold: got v=%b d=%h r=%b required 1/cafef00d/00", bus3.rvalid, bus3.rdata, bus3.rresp); else n_pass++;
      n_total++; if (bus3.arready !== 1'b0) $display("FAIL bp_arready: got %b required 0", bus3.arready); else n_pass++;
    end
    bus3.rready = 1'b1; @(posedge clk); #1; bus3.rready = 1'b0;
    n_total++; if (bus3.rvalid !== 1'b0 || bus3.arready !== 1'b1) $display("FAIL bp_release: got rvalid=%b arready=%b required 0/1", bus3.rvalid, bus3.arready); else n_pass++;
  endtask

  task automatic test_random_latency;
    int lat;
    logic [4:0] seen;
    seen = '0;
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
      busr.araddr = 32'h0000_1000; busr.arvalid = 1'b1;
      @(posedge clk); #1;
      busr.arvalid = 1'b0;
      lat = 0;
      while (!busr.rvalid && lat < 10) begin @(posedge clk); #1; lat++; end
      n_total++; if (lat < 1 || lat > 4 || busr.rresp !== 2'b10) $display("FAIL rand_latency: got lat=%0d resp=%b required 1..4/10", lat, busr.rresp); else n_pass++;
      if (lat >= 0 && lat <= 4) seen[lat] = 1'b1;
      busr.rready = 1'b1; @(posedge clk); #1; busr.rready = 1'b0;
    end
    n_total++; if ($countones(seen) < 2) $display("FAIL rand_spread: got latency set %b required at least two values", seen); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b0;
    bus1.araddr = '0; bus1.arvalid = 1'b0; bus1.rready = 1'b0; bus1.awaddr = '0; bus1.awvalid = 1'b0;
    bus1.wdata = '0; bus1.wstrb = '0; bus1.wvalid = 1'b0; bus1.bready = 1'b0;
    bus3.araddr = '0; bus3.arvalid = 1'b0; bus3.rready = 1'b0; bus3.awaddr = '0; bus3.awvalid = 1'b0;
    bus3.wdata = '0; bus3.wstrb = '0; bus3.wvalid = 1'b0; bus3.bready = 1'b0;
    busr.araddr = '0; busr.arvalid = 1'b0; busr.rready = 1'b0; busr.awaddr = '0; busr.awvalid = 1'b0;
    busr.wdata = '0; busr.wstrb = '0; busr.wvalid = 1'b0; busr.bready = 1'b0;
    test_reset;
    test_write_read;
    test_byte_strobe;
    test_out_of_range;
    test_random;
    test_contention;
    test_reset_midop;
    test_backpressure;
    test_random_latency;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
